pll_reset_sequencer: RTL and testbench
======================================

// Module: pll_reset_sequencer
// PURPOSE
//  Drives the PLL reset input and consumes its lock output, all on the always-running 50 MHz reference clock.
//  Pulses the PLL reset, waits for lock with a timeout and retry, and requires lock to stay stable before use.
//  Then deasserts a system reset request, which the 53.693175 MHz domain resynchronises locally.
//  On lock loss it re-sequences; after too many failed attempts it flags a fault.
// PARAMETERS
//  RST_CYCLES     32     cycles pll_rst is held high per attempt (>=1)
//  LOCK_TIMEOUT   50000  cycles to wait for lock before retrying (1 ms @ 50 MHz)
//  STABLE_CYCLES  1024   consecutive synced-lock cycles required before release
//  MAX_RETRIES    7      failed attempts before FAIL; 0 = retry forever
//  SYNC_STAGES    2      flops in the locked synchroniser (>=2)
// PORTS
//  clk          in   1  50 MHz reference clock (same net as the PLL refclk)
//  rst          in   1  reset; asynchronous assert, active-high
//  locked       in   1  PLL lock, asynchronous to clk
//  restart      in   1  single-cycle pulse: restart the sequence from scratch
//  pll_rst      out  1  to PLL rst input
//  sys_reset    out  1  system reset request, high until lock is qualified
//  ready        out  1  high only in RUN
//  fail         out  1  high only in FAIL
//  retry_count  out  8  failed attempts since the last rst/restart
//  loss_count   out  8  lock losses seen while in RUN; saturates at 255
//  state        out  3  current state code (debug)
// BEHAVIOUR
//  - Reset values:
//    - state=PLLRST, pll_rst=1, sys_reset=1, ready=0, fail=0.
//    - retry_count=0, loss_count=0, counter=0, synchroniser flops=0.
//  - All outputs are registered. lock_s is the SYNC_STAGES-flop synchronised version of locked; decisions use only lock_s.
//  - One shared counter cnt, width $clog2(max(RST_CYCLES,LOCK_TIMEOUT,STABLE_CYCLES)). It is cleared on every state change.
//  - restart has top priority in every state:
//    - next state PLLRST, cnt=0, retry_count=0; loss_count is kept.
//  - PLLRST (0): pll_rst=1, sys_reset=1. At cnt==RST_CYCLES-1, go to WAIT.
//  - WAIT (1): pll_rst=0.
//    - If lock_s, go to STABLE.
//    - Else, at cnt==LOCK_TIMEOUT-1:
//      - If MAX_RETRIES!=0 and retry_count==MAX_RETRIES, go to FAIL.
//      - Otherwise retry_count++ (saturating at 255) and go to PLLRST.
//  - STABLE (2):
//    - If !lock_s, go to WAIT; the timeout restarts and no retry is charged.
//    - At cnt==STABLE_CYCLES-1, go to RUN.
//  - RUN (3): sys_reset=0, ready=1.
//    - If !lock_s, go to PLLRST and loss_count++ (saturating).
//    - On that transition sys_reset=1 and ready=0 are registered on the same edge.
//  - FAIL (4): pll_rst=0, sys_reset=1, fail=1. Exits only via restart or rst.
//  - Latency: locked rising while in WAIT gives ready=1 exactly SYNC_STAGES+1+STABLE_CYCLES edges later.
//  - Latency: locked falling in RUN gives sys_reset=1 exactly SYNC_STAGES+1 edges later.
//  - lock_s rising on the same edge as the WAIT timeout: lock wins and the FSM goes to STABLE.
//  - rst asserted mid-sequence: immediate async return to the reset values; pll_rst goes high without waiting for clk.
//  - Unused state codes 5-7 recover to PLLRST.
// STRUCTURE
//  - Package pll_seq_pkg holds:
//    - the state enum (PLLRST=0, WAIT=1, STABLE=2, RUN=3, FAIL=4);
//    - the 3-bit state width;
//    - the 8-bit counter width;
//    - a cnt_w(RST,TO,ST) constant function.
//  - Sub-module sync_bit (parameter STAGES): async-reset flop chain for locked. Reused elsewhere for CDC of single bits.
//  - Top level: one FSM process with the counter and status counters; outputs are decoded from the next state into registers.
// TESTING
//  - Bench parameters: RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, MAX_RETRIES=2, SYNC_STAGES=2.
//  1 Release rst, locked=0 -> pll_rst high 4 cycles, then low. The bench raises locked at WAIT entry. ready=1 after 2+1+8 edges; sys_reset=0, retry_count=0.
//  2 locked held 0 -> attempts time out every 4+20 cycles, retry_count 1, 2. Third timeout gives fail=1, state=4, pll_rst=0, sys_reset=1.
//  3 In RUN, drop locked for 1 cycle -> sys_reset=1 3 edges later, loss_count=1, state=PLLRST, then normal re-lock.
//  4 In STABLE, glitch locked low at cnt=5 -> state returns to WAIT. retry_count unchanged; ready only after a fresh 8 stable cycles.
//  5 In FAIL, pulse restart -> state=PLLRST next edge, retry_count=0, fail=0, loss_count unchanged.
//  6 Assert rst between edges while in RUN -> pll_rst=1, sys_reset=1, ready=0 before the next clk edge, with all counters 0.

Source files
------------

// File: rtl/pll_seq_pkg.sv
// Shared types and widths for the PLL reset sequencer.
// cnt_w sizes the single shared phase counter from the three phase lengths.
package pll_seq_pkg;

    localparam int STATE_W = 3;
    localparam int CNT_W   = 8;

    typedef enum logic [STATE_W-1:0] {
        PLLRST = 3'd0,
        WAIT   = 3'd1,
        STABLE = 3'd2,
        RUN    = 3'd3,
        FAIL   = 3'd4
    } state_t;

    function automatic int cnt_w(input int rst_c, input int to_c, input int st_c);
        int m;
        m = rst_c;
        if (to_c > m) m = to_c;
        if (st_c > m) m = st_c;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/pll_seq_if.sv
// PLL-side and system-side signals of the reset sequencer.
// The master modport is the sequencer itself.
interface pll_seq_if;
    import pll_seq_pkg::*;

    logic               locked;
    logic               restart;
    logic               pll_rst;
    logic               sys_reset;
    logic               ready;
    logic               fail;
    logic [CNT_W-1:0]   retry_count;
    logic [CNT_W-1:0]   loss_count;
    logic [STATE_W-1:0] state;

    modport master (
        input  locked, restart,
        output pll_rst, sys_reset, ready, fail, retry_count, loss_count, state
    );

    modport slave (
        output locked, restart,
        input  pll_rst, sys_reset, ready, fail, retry_count, loss_count, state
    );

endinterface

// File: rtl/sync_bit.sv
// Single-bit synchroniser: STAGES-deep flop chain, async active-high clear.
module sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) chain <= '0;
        else     chain <= {chain[STAGES-2:0], d};
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// Pulses PLL reset, waits for a qualified lock, then releases the system reset.
// Retries on lock timeout, re-sequences on lock loss, faults after MAX_RETRIES.
module pll_reset_sequencer
    import pll_seq_pkg::*;
#(
    parameter int RST_CYCLES    = 32,
    parameter int LOCK_TIMEOUT  = 50000,
    parameter int STABLE_CYCLES = 1024,
    parameter int MAX_RETRIES   = 7,
    parameter int SYNC_STAGES   = 2
) (
    input  logic      clk,
    input  logic      rst,
    pll_seq_if.master bus
);

    localparam int CW = cnt_w(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);

    state_t           st, nxt;
    logic [CW-1:0]    cnt;
    logic             lock_s;
    logic             inc_retry, inc_loss;
    logic [CNT_W-1:0] retry_count, loss_count;
    logic             pll_rst_q, sys_reset_q, ready_q, fail_q;

    sync_bit #(.STAGES(SYNC_STAGES)) u_lock_sync (
        .clk (clk),
        .rst (rst),
        .d   (bus.locked),
        .q   (lock_s)
    );

    always_comb begin
        nxt       = st;
        inc_retry = 1'b0;
        inc_loss  = 1'b0;
        if (bus.restart) begin
            nxt = PLLRST;
        end else begin
            case (st)
                PLLRST: if (cnt == CW'(RST_CYCLES - 1)) nxt = WAIT;
                WAIT: begin
                    // lock beats a timeout that lands on the same edge
                    if (lock_s) begin
                        nxt = STABLE;
                    end else if (cnt == CW'(LOCK_TIMEOUT - 1)) begin
                        if (MAX_RETRIES != 0 && retry_count == CNT_W'(MAX_RETRIES)) begin
                            nxt = FAIL;
                        end else begin
                            nxt       = PLLRST;
                            inc_retry = 1'b1;
                        end
                    end
                end
                STABLE: begin
                    if (!lock_s)                               nxt = WAIT;
                    else if (cnt == CW'(STABLE_CYCLES - 1))    nxt = RUN;
                end
                RUN: begin
                    if (!lock_s) begin
                        nxt      = PLLRST;
                        inc_loss = 1'b1;
                    end
                end
                FAIL:    nxt = FAIL;
                default: nxt = PLLRST;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st          <= PLLRST;
            cnt         <= '0;
            retry_count <= '0;
            loss_count  <= '0;
            pll_rst_q   <= 1'b1;
            sys_reset_q <= 1'b1;
            ready_q     <= 1'b0;
            fail_q      <= 1'b0;
        end else begin
            st  <= nxt;
            // restart in PLLRST keeps the state but must still rewind the pulse
            cnt <= (nxt != st || bus.restart) ? '0 : cnt + CW'(1);
            if (bus.restart)
                retry_count <= '0;
            else if (inc_retry && retry_count != '1)
                retry_count <= retry_count + CNT_W'(1);
            if (inc_loss && loss_count != '1)
                loss_count <= loss_count + CNT_W'(1);
            pll_rst_q   <= (nxt == PLLRST);
            sys_reset_q <= (nxt != RUN);
            ready_q     <= (nxt == RUN);
            fail_q      <= (nxt == FAIL);
        end
    end

    assign bus.pll_rst     = pll_rst_q;
    assign bus.sys_reset   = sys_reset_q;
    assign bus.ready       = ready_q;
    assign bus.fail        = fail_q;
    assign bus.retry_count = retry_count;
    assign bus.loss_count  = loss_count;
    assign bus.state       = st;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed walk through the sequencer with randomised lock timing; expectations
// come from edge-count arithmetic on the phase lengths.
module tb_pll_reset_sequencer;

    localparam int RC  = 4;
    localparam int TO  = 20;
    localparam int SC  = 8;
    localparam int MR  = 2;
    localparam int SS  = 2;
    localparam int ATT = RC + TO;
    localparam int QUAL = SS + 1;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    pll_seq_if bus();

    pll_reset_sequencer #(
        .RST_CYCLES    (RC),
        .LOCK_TIMEOUT  (TO),
        .STABLE_CYCLES (SC),
        .MAX_RETRIES   (MR),
        .SYNC_STAGES   (SS)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_state"},     32'(bus.state), 0);
        chk({tag, "_pll_rst"},   32'(bus.pll_rst), 1);
        chk({tag, "_sys_reset"}, 32'(bus.sys_reset), 1);
        chk({tag, "_ready"},     32'(bus.ready), 0);
        chk({tag, "_fail"},      32'(bus.fail), 0);
        chk({tag, "_retry"},     32'(bus.retry_count), 0);
        chk({tag, "_loss"},      32'(bus.loss_count), 0);
    endtask

    initial begin
        int d, r, stab_at, ready_at, exp_state, exp_retry;
        logic exp_pll;

        rst         = 1'b1;
        bus.locked  = 1'b0;
        bus.restart = 1'b0;
        step(2);
        chk_reset_values("reset");

        // 1: power-up, lock appears exactly on the last WAIT edge
        rst = 1'b0;
        for (int k = 1; k <= RC; k++) begin
            step();
            chk("s1_pll_rst", 32'(bus.pll_rst), 32'(k < RC));
        end
        chk("s1_wait", 32'(bus.state), 1);
        step(TO - QUAL);
        bus.locked = 1'b1;
        for (int n = 1; n <= QUAL + SC; n++) begin
            step();
            chk("s1_ready", 32'(bus.ready), 32'(n >= QUAL + SC));
            if (n == QUAL) chk("s1_lock_wins", 32'(bus.state), 2);
        end
        chk("s1_sys_reset", 32'(bus.sys_reset), 0);
        chk("s1_retry", 32'(bus.retry_count), 0);

        // 3: one-cycle lock drop in RUN, then re-lock with locked held high
        bus.locked = 1'b0;
        ready_at = QUAL + RC + 1 + SC;
        for (int n = 1; n <= ready_at; n++) begin
            step();
            if (n == 1) bus.locked = 1'b1;
            chk("s3_ready", 32'(bus.ready), 32'(n < QUAL || n >= ready_at));
            chk("s3_sys_reset", 32'(bus.sys_reset), 32'(n >= QUAL && n < ready_at));
            if (n == QUAL) begin
                chk("s3_state", 32'(bus.state), 0);
                chk("s3_loss", 32'(bus.loss_count), 1);
                chk("s3_pll_rst", 32'(bus.pll_rst), 1);
            end
        end

        // 4: lose lock in RUN, re-lock after random delay, glitch seen at cnt=5
        bus.locked = 1'b0;
        step(QUAL);
        chk("s4_pllrst", 32'(bus.state), 0);
        chk("s4_loss", 32'(bus.loss_count), 2);
        step(RC);
        chk("s4_wait", 32'(bus.state), 1);
        d = int'($urandom_range(0, 10));
        step(d);
        bus.locked = 1'b1;
        step(QUAL);
        chk("s4_stable", 32'(bus.state), 2);
        step(3);
        bus.locked = 1'b0;
        step();
        bus.locked = 1'b1;
        for (int n = 2; n <= 4 + SC; n++) begin
            step();
            exp_state = (n < 3) ? 2 : (n == 3) ? 1 : (n < 4 + SC) ? 2 : 3;
            chk("s4_state", 32'(bus.state), 32'(exp_state));
            chk("s4_ready", 32'(bus.ready), 32'(n >= 4 + SC));
        end
        chk("s4_retry", 32'(bus.retry_count), 0);

        // 2: lock never returns; timeouts every RC+TO edges until FAIL
        bus.locked = 1'b0;
        for (int n = 1; n <= QUAL + (MR + 1) * ATT + 5; n++) begin
            step();
            if (n < QUAL) begin
                exp_pll = 1'b0; exp_retry = 0;
            end else if (n < QUAL + (MR + 1) * ATT) begin
                exp_pll = ((n - QUAL) % ATT) < RC;
                exp_retry = (n - QUAL) / ATT;
            end else begin
                exp_pll = 1'b0; exp_retry = MR;
            end
            chk("s2_pll_rst", 32'(bus.pll_rst), 32'(exp_pll));
            chk("s2_retry", 32'(bus.retry_count), 32'(exp_retry));
            chk("s2_fail", 32'(bus.fail), 32'(n >= QUAL + (MR + 1) * ATT));
        end
        chk("s2_state", 32'(bus.state), 4);
        chk("s2_sys_reset", 32'(bus.sys_reset), 1);
        chk("s2_loss", 32'(bus.loss_count), 3);

        // 5: restart out of FAIL, lock arrives at a random edge
        bus.restart = 1'b1;
        step();
        bus.restart = 1'b0;
        chk("s5_state", 32'(bus.state), 0);
        chk("s5_retry", 32'(bus.retry_count), 0);
        chk("s5_fail", 32'(bus.fail), 0);
        chk("s5_loss", 32'(bus.loss_count), 3);
        chk("s5_pll_rst", 32'(bus.pll_rst), 1);
        r = int'($urandom_range(1, 10));
        stab_at = (r + QUAL > RC + 2) ? r + QUAL : RC + 2;
        ready_at = stab_at + SC;
        for (int n = 2; n <= ready_at; n++) begin
            if (n - 1 == r) bus.locked = 1'b1;
            step();
            chk("s5_pll_rst", 32'(bus.pll_rst), 32'(n < RC + 1));
            chk("s5_ready", 32'(bus.ready), 32'(n >= ready_at));
        end

        // 6: async reset between edges while in RUN
        #2 rst = 1'b1;
        #1;
        chk_reset_values("s6_async");
        step();
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
